max7219_chain_receiver: RTL and testbench
=========================================

Name: max7219_chain_receiver

Overview:
- Synthesizable receiving end of the MAX7219 serial link: models N_DEV cascaded MAX7219 devices as seen by our SPI master.
- Shifts in mosi while cs is low and latches 16-bit words into per-device register files on the cs rising edge.
- Exposes every decoded register. Serves as the loopback and verification target for the SPI master, and as the display-state source for on-FPGA LED-matrix emulation.

Parameters:
- N_DEV, 2, number of cascaded devices; shift register width is 16*N_DEV.
- CNT_W, 6, width of the saturating bit counter; must satisfy 2^CNT_W-1 >= 16*N_DEV+1.

Ports:
- sck  in  1  clock; same sck that drives the master; all sampling on posedge.
- rst  in  1  asynchronous, active-high reset.
- mosi  in  1  serial data, MSB first, synchronous to sck.
- cs  in  1  active-low chip select / load; rising edge latches the frame.
- dout  out  1  daisy-chain output = shift register MSB (registered).
- frame_valid  out  1  one-cycle pulse after each latch.
- frame_err  out  1  one-cycle pulse, coincident with frame_valid, when the frame was short.
- digit  out  N_DEV*64  digit0..7 per device; device k occupies [64k+63:64k], digit d at [64k+8d+7:64k+8d].
- decode_mode  out  N_DEV*8  decode-mode register per device.
- intensity  out  N_DEV*4  intensity[3:0] per device.
- scan_limit  out  N_DEV*3  scan-limit[2:0] per device.
- shutdown_n  out  N_DEV  1 = normal operation, 0 = shutdown.
- display_test  out  N_DEV  display-test bit per device.

Behaviour:
- Reset (async, rst=1): shift register = 0, bit count = 0, cs_q = 1, dout = 0, frame_valid = 0, frame_err = 0. All digit, decode_mode, intensity and scan_limit fields = 0. shutdown_n = 0, display_test = 0.
- Every posedge with cs=0: sreg <= {sreg[16*N_DEV-2:0], mosi}; count <= min(count+1, 2^CNT_W-1).
- cs_q <= cs every cycle. A rise is detected when cs=1 and cs_q=0 at a posedge.
- Per-device word k = sreg[16k+15:16k]. The first word sent lands in the highest k.
  - With the master's 32-bit frame, device 1 gets {address[15:8], data[15:8]} and device 0 gets {address[7:0], data[7:0]}.
- Extra leading bits (the master's START bit, or oversize frames) shift out via dout and are ignored.
- On rise detection, at that same edge, each device decodes its word:
  - word[15:12] is ignored; addr = word[11:8], dat = word[7:0].
  - addr 0x0: no-op.
  - addr 0x1..0x8: digit[addr-1] <= dat.
  - addr 0x9: decode_mode <= dat.
  - addr 0xA: intensity <= dat[3:0].
  - addr 0xB: scan_limit <= dat[2:0].
  - addr 0xC: shutdown_n <= dat[0].
  - addr 0xD, 0xE: ignored.
  - addr 0xF: display_test <= dat[0].
- Also at the rise edge: frame_valid <= 1; frame_err <= (count < 16*N_DEV); count <= 0. The shift register is not cleared.
- Latency: register outputs and the pulses are visible the cycle after the posedge that first samples cs=1.
- Default master sequence: START plus 32 bit states give count = 33, no error. The FINISH state produces the rise; back-to-back frames are supported with no gap cycle.
- cs held high: no shifting, no latching, outputs stable.
- Count saturates and never wraps.
- Reset mid-frame: all state is cleared. A following rise latches a short frame (count < 16*N_DEV) with frame_err = 1.
- A glitch of cs low for 1 cycle, then high, is a short frame (count = 1).

Optional Feature:
- Macro: MAX7219_STRICT_LEN_EN.
- Defined: short frames (count < 16*N_DEV) are not latched into any register file. frame_valid and frame_err still pulse.
- Undefined: short frames are latched from the current shift register contents, matching the real chip; frame_err still pulses.

Decomposition:
- Package max7219_pkg:
  - WORD_W = 16.
  - Address localparams ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIM, ADDR_SHUTDOWN, ADDR_TEST.
  - Reset value constants.
- Sub-module max7219_regfile: one device's register file. Inputs are the 16-bit word and a load strobe; outputs are that device's fields. It is instantiated N_DEV times by a generate loop.
- The top level holds the shift register, bit counter, cs edge detect and strict-length gating.

Test Plan:
- Reset released, no traffic -> all digits 0, shutdown_n = 2'b00, intensity = 0, dout = 0, no pulses.
- Master sends address = 16'h0C01, data = 16'h0101 -> shutdown_n = 2'b10, dev0 digit0 = 8'h01, frame_valid pulse, frame_err = 0.
- Back-to-back frames:
  - Frame 1: address = 16'h0A0A, data = 16'h0F03 -> dev1 intensity = 4'hF, dev0 intensity = 4'h3.
  - Frame 2: address = 16'h0808, data = 16'hA55A -> dev1 digit7 = 8'hA5, dev0 digit7 = 8'h5A.
  - Intensities from frame 1 must be unchanged after frame 2.
- cs low for 10 cycles, then high:
  - -> frame_err = 1.
  - With MAX7219_STRICT_LEN_EN: no register changes.
  - Without it: registers reflect sreg decode.
- 48-bit frame: 16 bits 16'h0F01, then the 32-bit frame {16'h0001, 16'h0001} -> display_test = 2'b00; the first 16 bits appear on dout, delayed by 32 cycles.
- Assert rst mid-frame after 12 bits -> all outputs at reset values immediately (async). After release, cs rise -> frame_err = 1.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 chain receiver: word width, register
// addresses and per-device reset values.
package max7219_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam logic [7:0] RST_DIGIT      = '0;
  localparam logic [7:0] RST_DECODE     = '0;
  localparam logic [3:0] RST_INTENSITY  = '0;
  localparam logic [2:0] RST_SCANLIM    = '0;
  localparam logic       RST_SHUTDOWN_N = 1'b0;
  localparam logic       RST_TEST       = 1'b0;

  function automatic logic is_digit_addr(input logic [3:0] addr);
    return (addr >= ADDR_DIGIT0) && (addr <= ADDR_DIGIT7);
  endfunction

endpackage

// File: rtl/max7219_regfile.sv
// Register file of a single MAX7219 device: decodes one 16-bit word on a
// load strobe and holds the digit and control registers.
module max7219_regfile
  import max7219_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  output logic [63:0]       o_digit,
  output logic [7:0]        o_decode_mode,
  output logic [3:0]        o_intensity,
  output logic [2:0]        o_scan_limit,
  output logic              o_shutdown_n,
  output logic              o_display_test
);

  logic [7:0] r_digit [8];
  logic [7:0] r_decode_mode;
  logic [3:0] r_intensity;
  logic [2:0] r_scan_limit;
  logic       r_shutdown_n;
  logic       r_display_test;

  logic [3:0] w_addr;
  logic [7:0] w_dat;
  logic [3:0] w_digit_off;
  logic [2:0] w_digit_idx;

  // word[15:12] carries no meaning on the real part and is dropped here
  assign w_addr      = i_word[11:8];
  assign w_dat       = i_word[7:0];
  assign w_digit_off = w_addr - ADDR_DIGIT0;
  assign w_digit_idx = w_digit_off[2:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 8; i++) r_digit[i] <= RST_DIGIT;
      r_decode_mode  <= RST_DECODE;
      r_intensity    <= RST_INTENSITY;
      r_scan_limit   <= RST_SCANLIM;
      r_shutdown_n   <= RST_SHUTDOWN_N;
      r_display_test <= RST_TEST;
    end else if (i_load) begin
      if (is_digit_addr(w_addr)) r_digit[w_digit_idx] <= w_dat;
      case (w_addr)
        ADDR_DECODE:    r_decode_mode  <= w_dat;
        ADDR_INTENSITY: r_intensity    <= w_dat[3:0];
        ADDR_SCANLIM:   r_scan_limit   <= w_dat[2:0];
        ADDR_SHUTDOWN:  r_shutdown_n   <= w_dat[0];
        ADDR_TEST:      r_display_test <= w_dat[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    o_digit = '0;
    for (int unsigned i = 0; i < 8; i++) o_digit[8*i +: 8] = r_digit[i];
  end

  assign o_decode_mode  = r_decode_mode;
  assign o_intensity    = r_intensity;
  assign o_scan_limit   = r_scan_limit;
  assign o_shutdown_n   = r_shutdown_n;
  assign o_display_test = r_display_test;

endmodule

// File: rtl/max7219_chain_receiver.sv
// Receiving end of a chain of N_DEV MAX7219 devices: shift register, bit
// counter, cs edge detect. Define MAX7219_STRICT_LEN_EN to drop short frames.
module max7219_chain_receiver
  import max7219_pkg::*;
#(
  parameter int unsigned N_DEV = 2,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 sck,
  input  logic                 rst,
  input  logic                 mosi,
  input  logic                 cs,
  output logic                 dout,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [N_DEV*64-1:0]  digit,
  output logic [N_DEV*8-1:0]   decode_mode,
  output logic [N_DEV*4-1:0]   intensity,
  output logic [N_DEV*3-1:0]   scan_limit,
  output logic [N_DEV-1:0]     shutdown_n,
  output logic [N_DEV-1:0]     display_test
);

  localparam int unsigned SR_W = WORD_W * N_DEV;

  logic [SR_W-1:0]  r_sreg;
  logic [CNT_W-1:0] r_count;
  logic             r_cs_q;
  logic             r_frame_valid;
  logic             r_frame_err;

  logic w_rise;
  logic w_short;
  logic w_load;

  assign w_rise  = cs & ~r_cs_q;
  assign w_short = r_count < CNT_W'(SR_W);

`ifdef MAX7219_STRICT_LEN_EN
  assign w_load = w_rise & ~w_short;
`else
  assign w_load = w_rise;
`endif

  // The shift register is deliberately kept across frames, like the real chip
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      r_sreg        <= '0;
      r_count       <= '0;
      r_cs_q        <= 1'b1;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_cs_q        <= cs;
      r_frame_valid <= w_rise;
      r_frame_err   <= w_rise & w_short;
      if (!cs) begin
        r_sreg <= {r_sreg[SR_W-2:0], mosi};
        if (r_count != '1) r_count <= r_count + 1'b1;
      end else if (w_rise) begin
        r_count <= '0;
      end
    end
  end

  assign dout        = r_sreg[SR_W-1];
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;

  for (genvar k = 0; k < N_DEV; k++) begin : g_dev
    max7219_regfile u_regfile (
      .i_clk          (sck),
      .i_rst          (rst),
      .i_load         (w_load),
      .i_word         (r_sreg[WORD_W*k +: WORD_W]),
      .o_digit        (digit[64*k +: 64]),
      .o_decode_mode  (decode_mode[8*k +: 8]),
      .o_intensity    (intensity[4*k +: 4]),
      .o_scan_limit   (scan_limit[3*k +: 3]),
      .o_shutdown_n   (shutdown_n[k]),
      .o_display_test (display_test[k])
    );
  end

endmodule

// File: tb/tb_max7219_chain_receiver.sv
// Self-checking bench for max7219_chain_receiver: directed frame table,
// corner-case sequences and random frames against a bit-history model.
module tb_max7219_chain_receiver;

  localparam int unsigned N_DEV   = 2;
  localparam int unsigned CNT_W   = 6;
  localparam int          SR_W    = 32;
  localparam int          CNT_MAX = 63;

  logic                sck = 1'b0;
  logic                rst = 1'b1;
  logic                mosi = 1'b0;
  logic                cs = 1'b1;
  logic                dout, frame_valid, frame_err;
  logic [N_DEV*64-1:0] digit;
  logic [N_DEV*8-1:0]  decode_mode;
  logic [N_DEV*4-1:0]  intensity;
  logic [N_DEV*3-1:0]  scan_limit;
  logic [N_DEV-1:0]    shutdown_n, display_test;

  always #5 sck = ~sck;

  max7219_chain_receiver #(.N_DEV(N_DEV), .CNT_W(CNT_W)) dut (
    .sck(sck), .rst(rst), .mosi(mosi), .cs(cs), .dout(dout),
    .frame_valid(frame_valid), .frame_err(frame_err), .digit(digit),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test)
  );

  // Model: history of the last SR_W bits shifted in, plus per-device fields
  logic [7:0] m_digit [N_DEV][8];
  logic [7:0] m_dec   [N_DEV];
  logic [3:0] m_int   [N_DEV];
  logic [2:0] m_scan  [N_DEV];
  logic       m_shd   [N_DEV];
  logic       m_tst   [N_DEV];
  bit         hist[$];
  int         m_count;
  logic       m_csq, m_fv, m_fe;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_DEV; k++) begin
      for (int d = 0; d < 8; d++) m_digit[k][d] = 8'h00;
      m_dec[k] = 8'h00; m_int[k] = 4'h0; m_scan[k] = 3'h0;
      m_shd[k] = 1'b0;  m_tst[k] = 1'b0;
    end
    hist.delete();
    m_count = 0; m_csq = 1'b1; m_fv = 1'b0; m_fe = 1'b0;
  endtask

  task automatic model_latch();
    logic [SR_W-1:0] s;
    logic [15:0]     w;
    int              a;
    bit              apply;
    s = '0;
    for (int i = 0; i < SR_W; i++)
      if (i < hist.size()) s[i] = hist[hist.size()-1-i];
    apply = 1'b1;
`ifdef MAX7219_STRICT_LEN_EN
    if (m_count < SR_W) apply = 1'b0;
`endif
    if (apply) begin
      for (int k = 0; k < N_DEV; k++) begin
        w = s[16*k +: 16];
        a = int'(w[11:8]);
        if (a >= 1 && a <= 8) m_digit[k][a-1] = w[7:0];
        else if (a == 9)  m_dec[k]  = w[7:0];
        else if (a == 10) m_int[k]  = w[3:0];
        else if (a == 11) m_scan[k] = w[2:0];
        else if (a == 12) m_shd[k]  = w[0];
        else if (a == 15) m_tst[k]  = w[0];
      end
    end
  endtask

  task automatic model_edge(input logic m, input logic c);
    m_fv = 1'b0; m_fe = 1'b0;
    if (c == 1'b0) begin
      hist.push_back(m);
      if (hist.size() > SR_W) void'(hist.pop_front());
      if (m_count < CNT_MAX) m_count++;
    end else if (m_csq == 1'b0) begin
      model_latch();
      m_fv = 1'b1;
      m_fe = (m_count < SR_W);
      m_count = 0;
    end
    m_csq = c;
  endtask

  task automatic check_all();
    logic [N_DEV*64-1:0] ed;
    logic [N_DEV*8-1:0]  edec;
    logic [N_DEV*4-1:0]  eint;
    logic [N_DEV*3-1:0]  escan;
    logic [N_DEV-1:0]    eshd, etst;
    logic                edout;
    for (int k = 0; k < N_DEV; k++) begin
      for (int d = 0; d < 8; d++) ed[64*k + 8*d +: 8] = m_digit[k][d];
      edec[8*k +: 8] = m_dec[k];
      eint[4*k +: 4] = m_int[k];
      escan[3*k +: 3] = m_scan[k];
      eshd[k] = m_shd[k];
      etst[k] = m_tst[k];
    end
    edout = (hist.size() >= SR_W) ? hist[hist.size()-SR_W] : 1'b0;
    chk("digit", digit, ed);
    chk("decode_mode", decode_mode, edec);
    chk("intensity", intensity, eint);
    chk("scan_limit", scan_limit, escan);
    chk("shutdown_n", shutdown_n, eshd);
    chk("display_test", display_test, etst);
    chk("dout", dout, edout);
    chk("frame_valid", frame_valid, m_fv);
    chk("frame_err", frame_err, m_fe);
  endtask

  task automatic step(input logic m, input logic c);
    mosi = m;
    cs   = c;
    @(posedge sck);
    #1;
    model_edge(m, c);
    check_all();
  endtask

  task automatic send_bits(input logic [127:0] v, input int len);
    for (int i = len - 1; i >= 0; i--) step(v[i], 1'b0);
    step(1'b0, 1'b1);
  endtask

  task automatic send_master(input logic [15:0] a, input logic [15:0] d);
    logic [127:0] v;
    v = '0;
    v[32:0] = {1'b1, a[15:8], d[15:8], a[7:0], d[7:0]};
    send_bits(v, 33);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(posedge sck);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] field(input int sel);
    case (sel)
      0: return {14'b0, shutdown_n};
      1: return {8'b0, intensity};
      2: return {digit[127:120], digit[63:56]};
      3: return {14'b0, display_test};
      4: return {10'b0, scan_limit};
      5: return decode_mode;
      default: return {digit[71:64], digit[7:0]};
    endcase
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          sel1;
    logic [15:0] exp1;
    int          sel2;
    logic [15:0] exp2;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [15:0]  cap;
    logic [127:0] v;
    int           len;

    tbl[0] = '{16'h0C01, 16'h0101, 0, 16'h0002, 6, 16'h0001};
    tbl[1] = '{16'h0A0A, 16'h0F03, 1, 16'h00F3, 0, 16'h0002};
    tbl[2] = '{16'h0808, 16'hA55A, 2, 16'hA55A, 1, 16'h00F3};
    tbl[3] = '{16'h0B09, 16'h0705, 4, 16'h0038, 5, 16'h0005};
    tbl[4] = '{16'h0F0F, 16'h0100, 3, 16'h0002, 2, 16'hA55A};
    tbl[5] = '{16'hFDF0, 16'h33FF, 3, 16'h0002, 2, 16'hA55A};
    tbl[6] = '{16'h0C5C, 16'h0000, 0, 16'h0000, 1, 16'h00F3};

    model_reset();
    repeat (2) @(posedge sck);
    #1;
    check_all();
    chk("rst_shutdown", shutdown_n, 2'b00);
    chk("rst_digits", digit, '0);
    chk("rst_dout", dout, 1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b1);

    // Back-to-back master frames, no idle cycle between them
    for (int r = 0; r < 7; r++) begin
      send_master(tbl[r].addr, tbl[r].data);
      chk($sformatf("tbl%0d_valid", r), frame_valid, 1'b1);
      chk($sformatf("tbl%0d_err", r), frame_err, 1'b0);
      chk($sformatf("tbl%0d_a", r), field(tbl[r].sel1), tbl[r].exp1);
      chk($sformatf("tbl%0d_b", r), field(tbl[r].sel2), tbl[r].exp2);
    end

    // cs low for 10 cycles
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b1);
    chk("short10_err", frame_err, 1'b1);
    chk("short10_valid", frame_valid, 1'b1);

    // One-cycle glitch
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("glitch_err", frame_err, 1'b1);

    // cs held high: nothing moves
    for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'b1);

    // 48-bit frame: the leading 16 bits must come out on dout
    pulse_reset();
    v = '0;
    v[47:0] = {16'h0F01, 8'h00, 8'h00, 8'h01, 8'h01};
    cap = '0;
    for (int i = 0; i < 48; i++) begin
      step(v[47-i], 1'b0);
      if (i >= 31 && i <= 46) cap[46-i] = dout;
    end
    step(1'b0, 1'b1);
    chk("oversize_dout", cap, 16'h0F01);
    chk("oversize_test", display_test, 2'b00);
    chk("oversize_digit0", field(6), 16'h0001);
    chk("oversize_err", frame_err, 1'b0);

    // Saturating count: 70 bits must not wrap into a short frame
    v = {$urandom, $urandom, $urandom, $urandom};
    send_bits(v, 70);
    chk("sat_err", frame_err, 1'b0);
    chk("sat_valid", frame_valid, 1'b1);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_shutdown", shutdown_n, 2'b00);
    @(posedge sck);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("arst_err", frame_err, 1'b1);

    // Random traffic
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        send_master(16'($urandom), 16'($urandom));
      end else begin
        v = {$urandom, $urandom, $urandom, $urandom};
        len = $urandom_range(1, 100);
        send_bits(v, len);
      end
      repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
